// File: rtl/apb_i2c_csr_pkg.sv
// rtl/apb_i2c_csr_pkg.sv - register map, field positions and APB FSM states for apb_i2c_csr
package apb_i2c_csr_pkg;

  localparam int REG_CTRL     = 0;
  localparam int REG_STATUS   = 1;
  localparam int REG_TXDATA   = 2;
  localparam int REG_RXDATA   = 3;
  localparam int REG_SLVADDR  = 4;
  localparam int REG_IRQ_EN   = 5;
  localparam int REG_IRQ_STAT = 6;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_REPEAT   = 1;
  localparam int CTRL_SOFT_RST = 2;
  localparam int CTRL_TX_FLUSH = 3;
  localparam int CTRL_RX_FLUSH = 4;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_EMPTY  = 1;
  localparam int STAT_RX_FULL   = 2;
  localparam int STAT_RX_EMPTY  = 3;
  localparam int STAT_I2C_READY = 4;

  localparam int IRQ_TX_OVF = 0;
  localparam int IRQ_RX_UNF = 1;
  localparam int IRQ_DONE   = 2;
  localparam int IRQ_NACK   = 3;
  localparam int IRQ_W      = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

endpackage

// File: rtl/sticky_w1c_reg.sv
// rtl/sticky_w1c_reg.sv - sticky event bits with write-1-to-clear; a set in the clearing cycle wins
module sticky_w1c_reg
  import apb_i2c_csr_pkg::*;
#(
  parameter int W = IRQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] set_i,
  input  logic [W-1:0] clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign q_d = (q_q & ~clr_i) | set_i;
  assign q_o = q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/apb_i2c_csr.sv
// rtl/apb_i2c_csr.sv - APB3 CSR block for the I2C controller: wait-state FSM, FIFO strobes, W1C IRQ
module apb_i2c_csr
  import apb_i2c_csr_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 4,
  parameter int RD_WAIT      = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDRESSWIDTH-1:0] PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATAWIDTH-1:0]    PWDATA,
  output logic [DATAWIDTH-1:0]    PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    tx_push,
  output logic [7:0]              tx_wdata,
  input  logic                    tx_full,
  input  logic                    tx_empty,
  output logic                    rx_pop,
  input  logic [7:0]              rx_rdata,
  input  logic                    rx_full,
  input  logic                    rx_empty,
  output logic                    i2c_enable,
  output logic                    i2c_repeat_start,
  output logic                    i2c_soft_reset,
  output logic                    tx_flush,
  output logic                    rx_flush,
  output logic [6:0]              slave_addr,
  input  logic                    i2c_ready,
  input  logic                    evt_done,
  input  logic                    evt_nack,
  output logic                    irq
);

  apb_state_e state_q;
  logic [2:0] cnt_q;
  logic       first_q, rx_ok_q;

  logic       en_q, rs_q, srst_q, txf_q, rxf_q, irq_q;
  logic [6:0] slv_q;
  logic [IRQ_W-1:0] ien_q, ist, ist_set, ist_clr;
  logic [DATAWIDTH-1:0] prdata_q;

  logic a_ctrl, a_stat, a_tx, a_rx, a_sa, a_ien, a_ist, a_undef;
  logic done, wr, rd, wr_err, rd_err, wr_ok, rx_legal;
  logic [7:0] status, rdata;

  assign a_ctrl  = (PADDR == ADDRESSWIDTH'(REG_CTRL));
  assign a_stat  = (PADDR == ADDRESSWIDTH'(REG_STATUS));
  assign a_tx    = (PADDR == ADDRESSWIDTH'(REG_TXDATA));
  assign a_rx    = (PADDR == ADDRESSWIDTH'(REG_RXDATA));
  assign a_sa    = (PADDR == ADDRESSWIDTH'(REG_SLVADDR));
  assign a_ien   = (PADDR == ADDRESSWIDTH'(REG_IRQ_EN));
  assign a_ist   = (PADDR == ADDRESSWIDTH'(REG_IRQ_STAT));
  assign a_undef = !(a_ctrl | a_stat | a_tx | a_rx | a_sa | a_ien | a_ist);

  // PSEL is part of legality so a stale SETUP after a finished transfer never arms a pop
  assign rx_legal = PSEL && !PWRITE && a_rx && !rx_empty;

  assign PREADY = (state_q == ACCESS) && (cnt_q == 3'd0);
  assign done   = PREADY && PSEL && PENABLE;
  assign wr     = done && PWRITE;
  assign rd     = done && !PWRITE;

  assign wr_err  = a_undef | a_stat | a_rx | (a_tx & tx_full) | (a_sa & !i2c_ready);
  assign rd_err  = a_undef | a_tx | (a_rx & !rx_ok_q);
  assign wr_ok   = wr && !wr_err;
  assign PSLVERR = done && (PWRITE ? wr_err : rd_err);

  assign tx_push  = wr && a_tx && !tx_full;
  assign tx_wdata = tx_push ? PWDATA[7:0] : 8'h00;
  assign rx_pop   = (state_q == ACCESS) && first_q && rx_ok_q && PSEL && PENABLE;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      first_q <= 1'b0;
      rx_ok_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (PSEL && !PENABLE) state_q <= SETUP;
        SETUP: begin
          state_q <= ACCESS;
          first_q <= 1'b1;
          rx_ok_q <= rx_legal;
          cnt_q   <= rx_legal ? 3'(RD_WAIT) : 3'd0;
        end
        ACCESS: begin
          first_q <= 1'b0;
          if (!PSEL) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rx_ok_q <= 1'b0;
          end else if (!PENABLE) begin
            // a new setup phase arrived while we were still in ACCESS: restart
            state_q <= SETUP;
            rx_ok_q <= 1'b0;
          end else if (cnt_q == 3'd0) begin
            state_q <= SETUP;
            rx_ok_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    status = 8'h00;
    status[STAT_TX_FULL]   = tx_full;
    status[STAT_TX_EMPTY]  = tx_empty;
    status[STAT_RX_FULL]   = rx_full;
    status[STAT_RX_EMPTY]  = rx_empty;
    status[STAT_I2C_READY] = i2c_ready;
  end

  always_comb begin
    rdata = 8'h00;
    if (a_ctrl)      rdata = {6'b0, rs_q, en_q};
    else if (a_stat) rdata = status;
    else if (a_rx)   rdata = rx_rdata;
    else if (a_sa)   rdata = {1'b0, slv_q};
    else if (a_ien)  rdata = {4'b0, ien_q};
    else if (a_ist)  rdata = {4'b0, ist};
  end

  always_comb begin
    ist_set = '0;
    ist_set[IRQ_TX_OVF] = wr && a_tx && tx_full;
    ist_set[IRQ_RX_UNF] = rd && a_rx && !rx_ok_q;
    ist_set[IRQ_DONE]   = evt_done;
    ist_set[IRQ_NACK]   = evt_nack;
    ist_clr = (wr && a_ist) ? PWDATA[IRQ_W-1:0] : '0;
  end

  sticky_w1c_reg #(.W(IRQ_W)) u_irq_stat (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .set_i (ist_set),
    .clr_i (ist_clr),
    .q_o   (ist)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      srst_q   <= 1'b0;
      txf_q    <= 1'b0;
      rxf_q    <= 1'b0;
      slv_q    <= 7'd0;
      ien_q    <= '0;
      prdata_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      srst_q <= 1'b0;
      txf_q  <= 1'b0;
      rxf_q  <= 1'b0;
      irq_q  <= |(ist & ien_q);
      if (wr_ok && a_ctrl) begin
        en_q   <= PWDATA[CTRL_ENABLE];
        rs_q   <= PWDATA[CTRL_REPEAT];
        srst_q <= PWDATA[CTRL_SOFT_RST];
        txf_q  <= PWDATA[CTRL_TX_FLUSH];
        rxf_q  <= PWDATA[CTRL_RX_FLUSH];
      end
      if (wr_ok && a_sa)  slv_q <= PWDATA[6:0];
      if (wr_ok && a_ien) ien_q <= PWDATA[IRQ_W-1:0];
      if (rd) prdata_q <= rd_err ? '0 : DATAWIDTH'(rdata);
    end
  end

  assign PRDATA           = prdata_q;
  assign i2c_enable       = en_q;
  assign i2c_repeat_start = rs_q;
  assign i2c_soft_reset   = srst_q;
  assign tx_flush         = txf_q;
  assign rx_flush         = rxf_q;
  assign slave_addr       = slv_q;
  assign irq              = irq_q;

endmodule

// File: tb/tb_apb_i2c_csr.sv
// tb/tb_apb_i2c_csr.sv - self-checking bench for apb_i2c_csr with read/push scoreboards
module tb_apb_i2c_csr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] paddr = '0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic       tx_push, rx_pop;
  logic [7:0] tx_wdata;
  logic       tx_full = 1'b0, tx_empty = 1'b1;
  logic [7:0] rx_rdata = '0;
  logic       rx_full = 1'b0, rx_empty = 1'b1;
  logic       i2c_enable, i2c_repeat_start, i2c_soft_reset, tx_flush, rx_flush;
  logic [6:0] slave_addr;
  logic       i2c_ready = 1'b1;
  logic       evt_done = 1'b0, evt_nack = 1'b0;
  logic       irq;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];

  int cyc = 0;
  int tx_cnt = 0, pop_cnt = 0, pop_cyc = 0, rdy_cyc = 0;
  int srst_cnt = 0, txf_cnt = 0, rxf_cnt = 0;
  logic [7:0] tx_last = '0;

  apb_i2c_csr #(.DATAWIDTH(8), .ADDRESSWIDTH(4), .RD_WAIT(2)) dut (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .tx_push(tx_push), .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_pop(rx_pop), .rx_rdata(rx_rdata), .rx_full(rx_full), .rx_empty(rx_empty),
    .i2c_enable(i2c_enable), .i2c_repeat_start(i2c_repeat_start),
    .i2c_soft_reset(i2c_soft_reset), .tx_flush(tx_flush), .rx_flush(rx_flush),
    .slave_addr(slave_addr), .i2c_ready(i2c_ready), .evt_done(evt_done),
    .evt_nack(evt_nack), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_push) begin tx_cnt <= tx_cnt + 1; tx_last <= tx_wdata; end
    if (rx_pop) begin pop_cnt <= pop_cnt + 1; pop_cyc <= cyc; end
    if (pready && psel && penable) rdy_cyc <= cyc;
    if (i2c_soft_reset) srst_cnt <= srst_cnt + 1;
    if (tx_flush) txf_cnt <= txf_cnt + 1;
    if (rx_flush) rxf_cnt <= rxf_cnt + 1;
  end

  // One APB3 transfer; called and returns just after a rising edge
  task automatic apb(input logic wr, input logic [3:0] a, input logic [7:0] d, input logic keep,
                     output logic err, output int n);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = -1; err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready) begin n = i; err = pslverr; break; end
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL apb_timeout addr=%0d: no PREADY, required PREADY within 40 cycles", a);
    end
    @(posedge clk); #1;
    penable = 1'b0;
    if (!keep) begin psel = 1'b0; @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic e; int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({pready, pslverr, tx_push, rx_pop, irq} !== 5'b0) begin errors++;
      $display("FAIL reset_strobes got=%b required=00000", {pready, pslverr, tx_push, rx_pop, irq}); end
    checks++; if ({prdata, slave_addr, i2c_enable, i2c_soft_reset} !== 17'h0) begin errors++;
      $display("FAIL reset_regs prdata=%h slave_addr=%h en=%b required all 0", prdata, slave_addr, i2c_enable); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    apb(1'b1, 4'd0, 8'h01, 1'b0, e, n);
    exp_rd.push_back(8'h01);
    apb(1'b0, 4'd0, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front()) begin errors++;
      $display("FAIL ctrl_pre_reset got=%h required=01", prdata); end
    rx_empty = 1'b0; rx_rdata = 8'h77;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'd3;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rx_pop !== 1'b1) begin errors++;
      $display("FAIL rx_pop_before_reset got=%b required=1", rx_pop); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({pready, rx_pop, prdata, i2c_enable} !== 11'h0) begin errors++;
      $display("FAIL mid_reset pready=%b rx_pop=%b prdata=%h en=%b required all 0",
               pready, rx_pop, prdata, i2c_enable); end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_rd.push_back(8'h77);
    apb(1'b0, 4'd3, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || e !== 1'b0 || n != 3) begin errors++;
      $display("FAIL post_reset_read prdata=%h err=%b n=%0d required 77/0/3", prdata, e, n); end
    rx_empty = 1'b1;
  endtask

  task automatic test_ctrl();
    logic e; int n, s0, t0, r0;
    s0 = srst_cnt; t0 = txf_cnt; r0 = rxf_cnt;
    apb(1'b1, 4'd0, 8'h1C, 1'b0, e, n);
    repeat (3) @(posedge clk); #1;
    checks++; if (srst_cnt - s0 != 1 || txf_cnt - t0 != 1 || rxf_cnt - r0 != 1) begin errors++;
      $display("FAIL ctrl_pulses srst=%0d txf=%0d rxf=%0d required 1 each",
               srst_cnt - s0, txf_cnt - t0, rxf_cnt - r0); end
    exp_rd.push_back(8'h00);
    apb(1'b0, 4'd0, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front()) begin errors++;
      $display("FAIL ctrl_read_1c got=%h required=00", prdata); end
    apb(1'b1, 4'd0, 8'h03, 1'b0, e, n);
    checks++; if ({i2c_enable, i2c_repeat_start} !== 2'b11 || n != 1) begin errors++;
      $display("FAIL ctrl_levels got=%b n=%0d required 11 n=1", {i2c_enable, i2c_repeat_start}, n); end
  endtask

  task automatic test_txdata();
    logic e; int n, c0;
    tx_full = 1'b0; c0 = tx_cnt;
    exp_tx.push_back(8'hA5);
    apb(1'b1, 4'd2, 8'hA5, 1'b0, e, n);
    checks++; if (tx_cnt - c0 != 1 || tx_last !== exp_tx.pop_front() || e !== 1'b0) begin errors++;
      $display("FAIL tx_push pushes=%0d wdata=%h err=%b required 1/a5/0", tx_cnt - c0, tx_last, e); end
    tx_full = 1'b1; c0 = tx_cnt;
    apb(1'b1, 4'd2, 8'h5A, 1'b0, e, n);
    checks++; if (tx_cnt - c0 != 0 || e !== 1'b1) begin errors++;
      $display("FAIL tx_ovf pushes=%0d err=%b required 0/1", tx_cnt - c0, e); end
    exp_rd.push_back(8'h01);
    apb(1'b0, 4'd6, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front()) begin errors++;
      $display("FAIL tx_ovf_stat got=%h required=01", prdata); end
    apb(1'b1, 4'd6, 8'h01, 1'b0, e, n);
    tx_full = 1'b0;
  endtask

  task automatic test_rxdata();
    logic e; int n, p0;
    rx_rdata = 8'h3C; rx_empty = 1'b0; p0 = pop_cnt;
    exp_rd.push_back(8'h3C);
    apb(1'b0, 4'd3, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || e !== 1'b0) begin errors++;
      $display("FAIL rx_read prdata=%h err=%b required 3c/0", prdata, e); end
    checks++; if (pop_cnt - p0 != 1 || rdy_cyc - pop_cyc != 2 || n != 3) begin errors++;
      $display("FAIL rx_timing pops=%0d pop_to_ready=%0d n=%0d required 1/2/3",
               pop_cnt - p0, rdy_cyc - pop_cyc, n); end
    rx_empty = 1'b1; p0 = pop_cnt;
    exp_rd.push_back(8'h00);
    apb(1'b0, 4'd3, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || e !== 1'b1 || pop_cnt != p0 || n != 1) begin errors++;
      $display("FAIL rx_unf prdata=%h err=%b pops=%0d n=%0d required 00/1/0/1", prdata, e, pop_cnt - p0, n); end
    exp_rd.push_back(8'h02);
    apb(1'b0, 4'd6, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front()) begin errors++;
      $display("FAIL rx_unf_stat got=%h required=02", prdata); end
    apb(1'b1, 4'd6, 8'h02, 1'b0, e, n);
  endtask

  task automatic test_irq();
    logic e; int n;
    apb(1'b1, 4'd5, 8'h08, 1'b0, e, n);
    evt_nack = 1'b1;
    @(posedge clk); #1 evt_nack = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b required=0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b required=1", irq); end
    @(posedge clk); #1;
    evt_nack = 1'b1;
    apb(1'b1, 4'd6, 8'h08, 1'b1, e, n);
    evt_nack = 1'b0; psel = 1'b0;
    @(posedge clk); #1;
    exp_rd.push_back(8'h08);
    apb(1'b0, 4'd6, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || irq !== 1'b1) begin errors++;
      $display("FAIL set_wins stat=%h irq=%b required 08/1", prdata, irq); end
    apb(1'b1, 4'd6, 8'h08, 1'b0, e, n);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b required=0", irq); end
    @(posedge clk); #1 evt_done = 1'b1;
    @(posedge clk); #1 evt_done = 1'b0;
    exp_rd.push_back(8'h04);
    apb(1'b0, 4'd6, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || irq !== 1'b0) begin errors++;
      $display("FAIL irq_masked stat=%h irq=%b required 04/0", prdata, irq); end
    apb(1'b1, 4'd6, 8'h04, 1'b0, e, n);
  endtask

  task automatic test_errors();
    logic e; int n;
    i2c_ready = 1'b1; rx_empty = 1'b1; rx_full = 1'b0; tx_empty = 1'b1; tx_full = 1'b0;
    exp_rd.push_back(8'h1A);
    apb(1'b0, 4'd1, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || e !== 1'b0) begin errors++;
      $display("FAIL status_a got=%h err=%b required 1a/0", prdata, e); end
    exp_rd.push_back(8'h00);
    apb(1'b0, 4'd7, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || e !== 1'b1) begin errors++;
      $display("FAIL undef_read got=%h err=%b required 00/1", prdata, e); end
    apb(1'b1, 4'd4, 8'h50, 1'b0, e, n);
    checks++; if (slave_addr !== 7'h50 || e !== 1'b0) begin errors++;
      $display("FAIL slvaddr_write got=%h err=%b required 50/0", slave_addr, e); end
    i2c_ready = 1'b0;
    apb(1'b1, 4'd4, 8'h2A, 1'b0, e, n);
    checks++; if (slave_addr !== 7'h50 || e !== 1'b1) begin errors++;
      $display("FAIL slvaddr_busy got=%h err=%b required 50/1", slave_addr, e); end
    rx_empty = 1'b0; rx_full = 1'b1; tx_empty = 1'b0; tx_full = 1'b1;
    exp_rd.push_back(8'h05);
    apb(1'b0, 4'd1, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front()) begin errors++;
      $display("FAIL status_b got=%h required=05", prdata); end
    exp_rd.push_back(8'h00);
    apb(1'b0, 4'd2, 8'h00, 1'b0, e, n);
    checks++; if (prdata !== exp_rd.pop_front() || e !== 1'b1) begin errors++;
      $display("FAIL txdata_read got=%h err=%b required 00/1", prdata, e); end
    apb(1'b1, 4'd1, 8'hFF, 1'b0, e, n);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL status_write err=%b required=1", e); end
    i2c_ready = 1'b1; rx_empty = 1'b1; rx_full = 1'b0; tx_empty = 1'b1; tx_full = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic e; int n1, n2;
    apb(1'b1, 4'd5, 8'h05, 1'b1, e, n1);
    exp_rd.push_back(8'h05);
    apb(1'b0, 4'd5, 8'h00, 1'b0, e, n2);
    checks++; if (prdata !== exp_rd.pop_front() || n1 != 1 || n2 != 0) begin errors++;
      $display("FAIL back_to_back prdata=%h n1=%0d n2=%0d required 05/1/0", prdata, n1, n2); end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_txdata();
    test_rxdata();
    test_irq();
    test_errors();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
